// File: rtl/cond_pkg.sv
// Shared condition-code encodings and NZCV/FlagW bit positions for the
// execute-stage condition unit.
package cond_pkg;

  localparam int unsigned NZCV_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against registered NZCV.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0]        Cond,
  input  logic [NZCV_W-1:0] Flags,
  output logic              condition_met
);

  logic n, z, c, v;

  always_comb begin
    n = Flags[FLAG_N];
    z = Flags[FLAG_Z];
    c = Flags[FLAG_C];
    v = Flags[FLAG_V];
    condition_met = 1'b0;
    case (cond_e'(Cond))
      EQ: condition_met = z;
      NE: condition_met = ~z;
      CS: condition_met = c;
      CC: condition_met = ~c;
      MI: condition_met = n;
      PL: condition_met = ~n;
      VS: condition_met = v;
      VC: condition_met = ~v;
      HI: condition_met = c & ~z;
      LS: condition_met = ~c | z;
      GE: condition_met = (n == v);
      LT: condition_met = (n != v);
      GT: condition_met = ~z & (n == v);
      LE: condition_met = z | (n != v);
      AL: condition_met = 1'b1;
      NV: condition_met = 1'b0;
      default: condition_met = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV flag register, condition gating of
// PCSrc/RegWrite/MemWrite. Optional squash counter under COND_PERF_EN.
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned FLAG_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Valid,
  input  logic              Stall,
  input  logic [3:0]        Cond,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic [1:0]        FlagW,
  input  logic              PCS,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              NoWrite,
  output logic              PCSrc,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              CondEx,
`ifdef COND_PERF_EN
  output logic [CNT_W-1:0]  SquashCnt,
`endif
  output logic [FLAG_W-1:0] Flags
);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              cond_met;
  logic              advance;

  cond_check u_cond_check (
    .Cond          (Cond),
    .Flags         (flags_q),
    .condition_met (cond_met)
  );

  always_comb begin
    CondEx   = Valid & cond_met;
    PCSrc    = PCS & CondEx;
    RegWrite = RegW & CondEx & ~NoWrite;
    MemWrite = MemW & CondEx;
    Flags    = flags_q;
    advance  = Valid & ~Stall;
  end

  // NZ and CV halves are written independently; an unwritten half holds.
  always_comb begin
    flags_d = flags_q;
    if (advance && cond_met) begin
      if (FlagW[FLAGW_NZ]) begin
        flags_d[FLAG_N] = ALUFlags[FLAG_N];
        flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
      end
      if (FlagW[FLAGW_CV]) begin
        flags_d[FLAG_C] = ALUFlags[FLAG_C];
        flags_d[FLAG_V] = ALUFlags[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

`ifdef COND_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance && !cond_met && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign SquashCnt = cnt_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit; squash-counter tests build
// only when COND_PERF_EN is defined.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       reset, Valid, Stall, PCS, RegW, MemW, NoWrite;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0] Flags;
`ifdef COND_PERF_EN
  logic [15:0] SquashCnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cond_unit #(.FLAG_W(4), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .Valid    (Valid),
    .Stall    (Stall),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .NoWrite  (NoWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
`ifdef COND_PERF_EN
    .SquashCnt(SquashCnt),
`endif
    .Flags    (Flags)
  );

  task automatic drive(input logic v, input logic st, input logic [3:0] c,
                       input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw,
                       input logic nw);
    Valid = v; Stall = st; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; NoWrite = nw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic [3:0] f);
    drive(1, 0, 4'b1110, f, 2'b11, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
    tick();
    tick();
    total++;
    if (Flags !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", Flags);
    end
    reset = 1'b0;
    drive(0, 0, 4'b1110, 4'b0000, 2'b00, 1, 1, 1, 0);
    total++;
    if ({PCSrc, RegWrite, MemWrite, CondEx} !== 4'b0000) begin
      bad++; $display("FAIL reset_outs: got %b want 0000", {PCSrc, RegWrite, MemWrite, CondEx});
    end
  endtask

  task automatic test_al_write();
    drive(1, 0, 4'b1110, 4'b0110, 2'b11, 0, 1, 0, 0);
    total++;
    if (RegWrite !== 1'b1) begin
      bad++; $display("FAIL al_regwrite: got %b want 1", RegWrite);
    end
    tick();
    total++;
    if (Flags !== 4'b0110) begin
      bad++; $display("FAIL al_flags: got %b want 0110", Flags);
    end
  endtask

  task automatic test_eq_ne();
    load_flags(4'b0100);
    drive(1, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
    total++;
    if (PCSrc !== 1'b1) begin
      bad++; $display("FAIL eq_pcsrc: got %b want 1", PCSrc);
    end
    tick();
    drive(1, 0, 4'b0001, 4'b1111, 2'b11, 0, 0, 1, 0);
    total++;
    if (MemWrite !== 1'b0 || CondEx !== 1'b0) begin
      bad++; $display("FAIL ne_memwrite: got %b%b want 00", MemWrite, CondEx);
    end
    tick();
    total++;
    if (Flags !== 4'b0100) begin
      bad++; $display("FAIL ne_flags_held: got %b want 0100", Flags);
    end
  endtask

  task automatic test_split_halves();
    load_flags(4'b0000);
    drive(1, 0, 4'b1110, 4'b1011, 2'b10, 0, 0, 0, 0);
    tick();
    total++;
    if (Flags !== 4'b1000) begin
      bad++; $display("FAIL split_nz: got %b want 1000", Flags);
    end
    drive(1, 0, 4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0);
    tick();
    total++;
    if (Flags !== 4'b1011) begin
      bad++; $display("FAIL split_cv: got %b want 1011", Flags);
    end
  endtask

  task automatic test_cmp();
    drive(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 1);
    total++;
    if (RegWrite !== 1'b0 || CondEx !== 1'b1) begin
      bad++; $display("FAIL cmp_regwrite: got %b%b want 01", RegWrite, CondEx);
    end
    tick();
    total++;
    if (Flags !== 4'b0100) begin
      bad++; $display("FAIL cmp_flags: got %b want 0100", Flags);
    end
    drive(1, 0, 4'b1100, 4'b1111, 2'b11, 0, 0, 0, 0);
    total++;
    if (CondEx !== 1'b0) begin
      bad++; $display("FAIL gt_condex: got %b want 0", CondEx);
    end
    tick();
    total++;
    if (Flags !== 4'b0100) begin
      bad++; $display("FAIL gt_no_update: got %b want 0100", Flags);
    end
  endtask

  task automatic test_stall_bubble();
    drive(1, 1, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0);
    total++;
    if (RegWrite !== 1'b1 || CondEx !== 1'b1) begin
      bad++; $display("FAIL stall_outs: got %b%b want 11", RegWrite, CondEx);
    end
    tick();
    total++;
    if (Flags !== 4'b0100) begin
      bad++; $display("FAIL stall_flags: got %b want 0100", Flags);
    end
    drive(0, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 0);
    total++;
    if ({PCSrc, RegWrite, MemWrite, CondEx} !== 4'b0000) begin
      bad++; $display("FAIL bubble_outs: got %b want 0000", {PCSrc, RegWrite, MemWrite, CondEx});
    end
    tick();
    total++;
    if (Flags !== 4'b0100) begin
      bad++; $display("FAIL bubble_flags: got %b want 0100", Flags);
    end
  endtask

  task automatic test_cond_table();
    logic [3:0]  fv  [4] = '{4'b0000, 4'b1010, 4'b0111, 4'b1101};
    logic [15:0] msk [4] = '{16'h56AA, 16'h6996, 16'h6A65, 16'h6659};
    for (int i = 0; i < 4; i++) begin
      load_flags(fv[i]);
      for (int c = 0; c < 16; c++) begin
        drive(1, 0, 4'(c), 4'b0000, 2'b00, 0, 0, 0, 0);
        total++;
        if (CondEx !== msk[i][c]) begin
          bad++; $display("FAIL cond_table flags=%b cond=%0d: got %b want %b", fv[i], c, CondEx, msk[i][c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    load_flags(4'b0000);
    drive(1, 0, 4'b0000, 4'b0100, 2'b11, 1, 0, 0, 0);
    total++;
    if (CondEx !== 1'b0) begin
      bad++; $display("FAIL no_forward: got %b want 0", CondEx);
    end
    tick();
    drive(1, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
    tick();
    drive(1, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
    total++;
    if (PCSrc !== 1'b1) begin
      bad++; $display("FAIL b2b_pcsrc: got %b want 1", PCSrc);
    end
  endtask

  task automatic test_reset_wins();
    load_flags(4'b1111);
    reset = 1'b1;
    drive(1, 0, 4'b1110, 4'b0101, 2'b11, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    total++;
    if (Flags !== 4'b0000) begin
      bad++; $display("FAIL reset_wins: got %b want 0000", Flags);
    end
    load_flags(4'b1010);
    reset = 1'b1;
    drive(1, 1, 4'b1110, 4'b1111, 2'b11, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    total++;
    if (Flags !== 4'b0000) begin
      bad++; $display("FAIL reset_mid_stall: got %b want 0000", Flags);
    end
  endtask

`ifdef COND_PERF_EN
  task automatic test_counter();
    reset = 1'b1;
    drive(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    total++;
    if (SquashCnt !== 16'd0) begin
      bad++; $display("FAIL cnt_reset: got %0d want 0", SquashCnt);
    end
    drive(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 1, 0);
    repeat (3) tick();
    total++;
    if (SquashCnt !== 16'd3) begin
      bad++; $display("FAIL cnt_three: got %0d want 3", SquashCnt);
    end
    drive(1, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
    tick();
    drive(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
    tick();
    drive(1, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0);
    tick();
    total++;
    if (SquashCnt !== 16'd3) begin
      bad++; $display("FAIL cnt_held: got %0d want 3", SquashCnt);
    end
    drive(1, 0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0);
    repeat (65536) tick();
    total++;
    if (SquashCnt !== 16'hFFFF) begin
      bad++; $display("FAIL cnt_saturate: got %h want ffff", SquashCnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive(0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0);
    test_reset();
    test_al_write();
    test_eq_ne();
    test_split_halves();
    test_cmp();
    test_stall_bubble();
    test_cond_table();
    test_back_to_back();
    test_reset_wins();
`ifdef COND_PERF_EN
    test_counter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
